// File: rtl/fetch_sequencer_if.sv
// Fetch-side bundle of the fetch sequencer.
//   rom_addr / rom_data               : combinational instruction ROM lookup
//   redirect_valid / redirect_target  : branch/jump redirect from later stages
//   instr_valid / instr / instr_pc /
//   instr_ready                       : valid/ready handoff to decode
// master = the sequencer, slave = the ROM/decode side.
interface fetch_sequencer_if;
  logic [31:0] rom_addr;
  logic [31:0] rom_data;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;

  modport master (
    output rom_addr, instr_valid, instr, instr_pc,
    input  rom_data, redirect_valid, redirect_target, instr_ready
  );

  modport slave (
    input  rom_addr, instr_valid, instr, instr_pc,
    output rom_data, redirect_valid, redirect_target, instr_ready
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: walks a word-aligned pc through a
// combinational ROM, queues {pc, word} pairs in a 2-entry FIFO for decode,
// stalls when the FIFO is full, halts on the HALT_WORD encoding and
// restarts at a redirect target.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   bus          : fetch_sequencer_if.master (ROM, redirect, decode handoff)
//   halted       : high while sequential fetch is halted
//   fetch_count  : saturating count of words pushed since reset
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] HALT_WORD = 32'hA800_FFFF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  fetch_sequencer_if.master         bus,
  output logic                      halted,
  output logic [15:0]               fetch_count
);

  typedef enum logic [1:0] {FETCH, HOLD, HALT} state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] word;
  } entry_t;

  state_t      state;
  logic [31:0] pc;
  entry_t      head;   // FIFO slot 0, always the oldest entry
  entry_t      tail;   // FIFO slot 1, valid only when occupancy is 2
  logic [1:0]  occupancy;

  logic   push;
  logic   pop;
  logic   halt_hit;
  entry_t fetched;

  // Target bits [1:0] are dropped to keep fetches word-aligned.
  logic unused_target_bits;
  assign unused_target_bits = ^bus.redirect_target[1:0];

  assign bus.rom_addr    = pc;
  assign bus.instr_valid = (occupancy != 2'd0);
  assign bus.instr       = head.word;
  assign bus.instr_pc    = head.pc;

  // NOTE: every signal written in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    pop      = 1'b0;
    push     = 1'b0;
    halt_hit = 1'b0;
    fetched  = '{pc: pc, word: bus.rom_data};
    if (!bus.redirect_valid) begin
      pop      = bus.instr_valid && bus.instr_ready;
      // A full FIFO can still take a word when the head leaves this cycle.
      push     = (state == FETCH) && ((occupancy != 2'd2) || pop);
      halt_hit = push && (bus.rom_data == HALT_WORD);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= FETCH;
      pc          <= RESET_PC;
      // NOTE: FIFO storage is reset too, because instr/instr_pc are read
      // straight from it and must be zero while reset is asserted.
      head        <= '0;
      tail        <= '0;
      occupancy   <= 2'd0;
      halted      <= 1'b0;
      fetch_count <= 16'd0;
    end else if (bus.redirect_valid) begin
      // Flush wins over everything: no push, no pop this cycle.
      occupancy <= 2'd0;
      pc        <= {bus.redirect_target[31:2], 2'b00};
      state     <= FETCH;
      halted    <= 1'b0;
    end else begin
      unique case ({push, pop})
        2'b10: begin
          if (occupancy == 2'd0) head <= fetched;
          else                   tail <= fetched;
          occupancy <= occupancy + 2'd1;
        end
        2'b01: begin
          head      <= tail;
          occupancy <= occupancy - 2'd1;
        end
        2'b11: begin
          // Occupancy is unchanged; shift first so order is preserved.
          if (occupancy == 2'd2) begin
            head <= tail;
            tail <= fetched;
          end else begin
            head <= fetched;
          end
        end
        default: ;
      endcase

      if (push) begin
        if (fetch_count != 16'hFFFF) fetch_count <= fetch_count + 16'd1;
        // The halt word stays on rom_addr; pc + 4 wraps naturally at 2^32.
        if (!halt_hit) pc <= pc + 32'd4;
      end

      unique case (state)
        FETCH: begin
          if (halt_hit) begin
            state  <= HALT;
            halted <= 1'b1;
          end else if (push && !pop && (occupancy == 2'd1)) begin
            state <= HOLD;
          end
        end
        HOLD:    if (pop) state <= FETCH;
        HALT:    ;  // only a redirect or reset leaves HALT
        default: state <= FETCH;
      endcase
    end
  end

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 Parameter: RESET_PC, default 32'h0000_0000, word-aligned address of the first fetch after reset.
REQ-002 Parameter: HALT_WORD, default 32'hA800_FFFF, the instruction encoding (JMP -1) that halts sequential fetch.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 rom_addr  output  32  byte address driven to the combinational instruction ROM.
REQ-006 rom_data  input  32  instruction word returned by the ROM in the same cycle.
REQ-007 redirect_valid  input  1  branch/jump taken; flush and refetch.
REQ-008 redirect_target  input  32  new fetch address; bits [1:0] ignored and treated as 0.
REQ-009 instr_valid  output  1  FIFO head holds a valid instruction.
REQ-010 instr  output  32  instruction at FIFO head.
REQ-011 instr_pc  output  32  byte address of instr.
REQ-012 instr_ready  input  1  decode accepts head when high with instr_valid high.
REQ-013 halted  output  1  high while in HALT state.
REQ-014 fetch_count  output  16  saturating count of words pushed since reset.

Function
REQ-015 Registers: pc (32), 2-entry FIFO of {pc, instr}, occupancy (0..2), state, fetch_count.
REQ-016 rom_addr SHALL equal pc combinationally in every state.
REQ-017 States: FETCH, HOLD, HALT; reset state FETCH.
REQ-018 A push occurs in a cycle iff state is FETCH, redirect_valid is low, and (occupancy<2 or a pop occurs that cycle); a push stores {pc, rom_data} and sets pc to pc+4.
REQ-019 A pop occurs iff instr_valid and instr_ready are both high; the head advances and occupancy drops by 1.
REQ-020 Simultaneous push and pop at occupancy 2 or 1 SHALL leave occupancy unchanged with order preserved.
REQ-021 pc+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-022 FETCH -> HOLD when a push brings occupancy to 2 with no pop; HOLD -> FETCH when occupancy drops below 2; no push in HOLD.
REQ-023 FETCH -> HALT when the pushed rom_data equals HALT_WORD; the halt word itself is enqueued and pc stays at its address (not incremented).
REQ-024 In HALT no pushes occur; pops continue until FIFO drains; halted=1.
REQ-025 redirect_valid high in any state SHALL, at the next edge, clear the FIFO (occupancy 0), set pc to {redirect_target[31:2],2'b00}, enter FETCH; no push or pop occurs that cycle, even if instr_ready is high.
REQ-026 instr_valid SHALL be occupancy!=0; instr/instr_pc SHALL be held stable while instr_valid is high and instr_ready is low.
REQ-027 Latency: a word fetched at edge N is visible on instr at edge N when FIFO was empty (available the cycle after it is driven on rom_addr).
REQ-028 fetch_count increments by 1 per push, saturating at 16'hFFFF; redirects do not clear it.

Reset
REQ-029 rst_n low SHALL immediately force pc=RESET_PC, occupancy=0, state=FETCH, fetch_count=0, instr_valid=0, halted=0, instr=0, instr_pc=0.
REQ-030 Reset asserted mid-operation (any state, any occupancy) SHALL discard all in-flight instructions; first fetch after release is RESET_PC.

Verification
REQ-031 Release reset, instr_ready=1, ROM word0=32'h8001_060A, word4=32'h0401_1000 -> cycle 1 instr=32'h8001060A instr_pc=0, cycle 2 instr=32'h04011000 instr_pc=4, one instruction per cycle.
REQ-032 instr_ready=0 from reset -> occupancy reaches 2 (pc=8, HOLD), instr stays 32'h8001060A; raise instr_ready -> pcs 0,4,8 delivered in order, no loss or duplicate.
REQ-033 redirect_valid=1 with target 32'h0000_00B3 while FIFO holds 2 -> next cycle instr_valid=0, rom_addr=32'h0000_00B0; following cycle instr_pc=32'hB0.
REQ-034 Fetch reaches address 252 holding 32'hA800_FFFF -> halted=1, rom_addr stays 252, FIFO drains, instr_valid=0 thereafter; redirect to 0 -> halted=0, fetch resumes at 0.
REQ-035 Redirect to 32'hFFFF_FFFC -> following fetch address 32'h0000_0000; assert rst_n=0 mid-stream -> outputs zero immediately, fetch_count=0.
